// File: rtl/mfhwt_pkg.sv
// Shared encodings and default geometry for the Haar averaging line-buffer stages.
package mfhwt_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, READ = 2'd2} bank_st_e;
  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} rd_st_e;

  localparam int DEF_LINE_W  = 640;
  localparam int DEF_FRAME_H = 480;
  localparam int DEF_ROWS    = 4;
endpackage

// File: rtl/mfhwt_linebuf_sched_if.sv
// Handshake/bus bundle between a line-buffer scheduler and its averager/buffer neighbours.
// Optional MFHWT_SCHED_STATS_EN adds the oDrop_cnt statistic.
interface mfhwt_linebuf_sched_if #(parameter int ROWS = mfhwt_pkg::DEF_ROWS);
  logic            iData_valid;
  logic            iRd_enable;
  logic            oSelect;
  logic [ROWS-1:0] oWrreq;
  logic            oRd_bank;
  logic            oRdreq;
  logic            oRd_valid;
  logic            oOverflow;
  logic            oFrame_done;
  logic            oBusy;
`ifdef MFHWT_SCHED_STATS_EN
  logic [15:0]     oDrop_cnt;

  modport master (input iData_valid, iRd_enable,
                  output oSelect, oWrreq, oRd_bank, oRdreq, oRd_valid,
                         oOverflow, oFrame_done, oBusy, oDrop_cnt);
  modport slave  (output iData_valid, iRd_enable,
                  input oSelect, oWrreq, oRd_bank, oRdreq, oRd_valid,
                        oOverflow, oFrame_done, oBusy, oDrop_cnt);
`else
  modport master (input iData_valid, iRd_enable,
                  output oSelect, oWrreq, oRd_bank, oRdreq, oRd_valid,
                         oOverflow, oFrame_done, oBusy);
  modport slave  (output iData_valid, iRd_enable,
                  input oSelect, oWrreq, oRd_bank, oRdreq, oRd_valid,
                        oOverflow, oFrame_done, oBusy);
`endif
endinterface

// File: rtl/mfhwt_valid_pipe.sv
// RD_LAT-deep valid shift register; tap 0 is the live input, tap RD_LAT the delayed copy.
module mfhwt_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic iClear,
  input  logic iIn,
  output logic oOut
);
  logic [RD_LAT:0] vld_pipe;
  logic [RD_LAT:1] vld_q;

  always_comb vld_pipe = {vld_q, iIn};

  always_ff @(posedge iClk)
    if (!iReset_n || iClear) vld_q <= '0;
    else                     vld_q <= vld_pipe[RD_LAT-1:0];

  assign oOut = vld_pipe[RD_LAT];
endmodule

// File: rtl/mfhwt_linebuf_sched.sv
// Ping-pong ROWS-line buffer sequencer: row steering, bank ownership, column-burst reads.
// Optional MFHWT_SCHED_STATS_EN adds a saturating dropped-word counter on oDrop_cnt.
module mfhwt_linebuf_sched
  import mfhwt_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int ROWS    = DEF_ROWS,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int RD_LAT  = 1
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iFrame_start,
  mfhwt_linebuf_sched_if.master bus
);
  localparam int CW = $clog2(LINE_W);
  localparam int RW = $clog2(ROWS);
  localparam int NG = FRAME_H / ROWS;
  localparam int GW = $clog2(NG + 1);
  localparam logic [CW-1:0]   COL_LAST = CW'(LINE_W - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
  localparam logic [GW-1:0]   GRP_LAST = GW'(NG - 1);
  localparam logic [ROWS-1:0] ONE      = ROWS'(1);

  bank_st_e      bank_q [2];
  bank_st_e      bank_d [2];
  rd_st_e        rst_q, rst_d;
  logic          sel_q, sel_d, rbank_q, rbank_d;
  logic          gdrop_q, gdrop_d, ovf_q, ovf_d, fdone_q, fdone_d;
  logic [CW-1:0] col_q, col_d, rcol_q, rcol_d;
  logic [RW-1:0] row_q, row_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          live, wr_ok, wr_drop, last_word, rd_acc, rd_last;

  // Frame start outranks everything, so no word or read is honoured in its cycle.
  assign live      = iReset_n && !iFrame_start;
  assign wr_ok     = live && bus.iData_valid && (bank_q[sel_q] == EMPTY);
  assign wr_drop   = live && bus.iData_valid && (bank_q[sel_q] != EMPTY);
  assign last_word = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign rd_acc    = live && (rst_q == R_BURST) && bus.iRd_enable;
  assign rd_last   = rd_acc && (rcol_q == COL_LAST);

  always_ff @(posedge iClk) begin
    if (!iReset_n || iFrame_start) begin
      rst_q   <= R_IDLE;
      bank_q  <= '{EMPTY, EMPTY};
      sel_q   <= 1'b0;
      rbank_q <= 1'b0;
      gdrop_q <= 1'b0;
      ovf_q   <= 1'b0;
      fdone_q <= 1'b0;
      col_q   <= '0;
      rcol_q  <= '0;
      row_q   <= '0;
      grp_q   <= '0;
    end else begin
      rst_q   <= rst_d;
      bank_q  <= bank_d;
      sel_q   <= sel_d;
      rbank_q <= rbank_d;
      gdrop_q <= gdrop_d;
      ovf_q   <= ovf_d;
      fdone_q <= fdone_d;
      col_q   <= col_d;
      rcol_q  <= rcol_d;
      row_q   <= row_d;
      grp_q   <= grp_d;
    end
  end

  always_comb begin
    rst_d = rst_q;
    if (rst_q == R_IDLE) begin
      if (bank_q[0] == FULL || bank_q[1] == FULL) rst_d = R_BURST;
    end else if (rd_last && bank_q[~rbank_q] != FULL) begin
      rst_d = R_IDLE;
    end
  end

  // Write and read sides never target the same bank in one cycle: writes only
  // complete an EMPTY bank, reads only claim FULL banks and release READ ones.
  always_comb begin
    bank_d  = bank_q;
    sel_d   = sel_q;
    col_d   = col_q;
    row_d   = row_q;
    gdrop_d = gdrop_q;
    ovf_d   = ovf_q;
    rbank_d = rbank_q;
    rcol_d  = rcol_q;
    grp_d   = grp_q;
    fdone_d = 1'b0;
    if (live && bus.iData_valid) begin
      if (wr_drop) begin
        ovf_d   = 1'b1;
        gdrop_d = 1'b1;
      end
      col_d = col_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end
      if (last_word) begin
        row_d   = '0;
        if (wr_ok && !gdrop_q) bank_d[sel_q] = FULL;
        sel_d   = ~sel_q;
        gdrop_d = 1'b0;
      end
    end
    if (live && rst_q == R_IDLE) begin
      if (bank_q[0] == FULL) begin
        rbank_d   = 1'b0;
        bank_d[0] = READ;
        rcol_d    = '0;
      end else if (bank_q[1] == FULL) begin
        rbank_d   = 1'b1;
        bank_d[1] = READ;
        rcol_d    = '0;
      end
    end
    if (rd_acc) begin
      rcol_d = rcol_q + 1'b1;
      if (rd_last) begin
        bank_d[rbank_q] = EMPTY;
        rcol_d          = '0;
        // Done is flagged on the edge that retires the final group of the frame.
        if (grp_q == GRP_LAST) begin
          grp_d   = '0;
          fdone_d = 1'b1;
        end else begin
          grp_d = grp_q + 1'b1;
        end
        if (bank_q[~rbank_q] == FULL) begin
          rbank_d          = ~rbank_q;
          bank_d[~rbank_q] = READ;
        end
      end
    end
  end

  always_comb begin
    bus.oWrreq = '0;
    if (wr_ok) bus.oWrreq = ONE << row_q;
    bus.oRdreq = rd_acc;
  end

  assign bus.oSelect     = sel_q;
  assign bus.oRd_bank    = rbank_q;
  assign bus.oOverflow   = ovf_q;
  assign bus.oFrame_done = fdone_q;
  assign bus.oBusy       = (bank_q[0] != EMPTY) || (bank_q[1] != EMPTY) ||
                           (col_q != '0) || (row_q != '0);

  mfhwt_valid_pipe #(.RD_LAT(RD_LAT)) u_vpipe (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iClear   (iFrame_start),
    .iIn      (rd_acc),
    .oOut     (bus.oRd_valid)
  );

`ifdef MFHWT_SCHED_STATS_EN
  logic [15:0] dcnt_q, dcnt_d;

  always_comb dcnt_d = (wr_drop && dcnt_q != 16'hFFFF) ? dcnt_q + 16'd1 : dcnt_q;

  always_ff @(posedge iClk)
    if (!iReset_n || iFrame_start) dcnt_q <= '0;
    else                           dcnt_q <= dcnt_d;

  assign bus.oDrop_cnt = dcnt_q;
`endif
endmodule

// File: tb/tb_mfhwt_linebuf_sched.sv
// Directed bench for mfhwt_linebuf_sched at LINE_W=8, ROWS=4, FRAME_H=8, RD_LAT=1.
module tb_mfhwt_linebuf_sched;
  logic clk, rst_n, fs;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [9:0] pat;

  mfhwt_linebuf_sched_if #(.ROWS(4)) bus ();

  mfhwt_linebuf_sched #(.LINE_W(8), .ROWS(4), .FRAME_H(8), .RD_LAT(1)) dut (
    .iClk         (clk),
    .iReset_n     (rst_n),
    .iFrame_start (fs),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fs = 1'b0; bus.iData_valid = 1'b1; bus.iRd_enable = 1'b0;
    tick(); tick();
    #1;
    chk("rst_wrreq",  32'(bus.oWrreq), 32'h0);
    chk("rst_rdreq",  32'(bus.oRdreq), 32'h0);
    chk("rst_ovf",    32'(bus.oOverflow), 32'h0);
    chk("rst_sel",    32'(bus.oSelect), 32'h0);
    chk("rst_busy",   32'(bus.oBusy), 32'h0);
    chk("rst_rdbank", 32'(bus.oRd_bank), 32'h0);
    tick();

    // Fill bank 0: rows 0..3 of 8 words each.
    rst_n = 1'b1;
    for (int w = 0; w < 32; w++) begin
      #1;
      chk("fill0_wrreq", 32'(bus.oWrreq), 32'(1 << (w / 8)));
      tick();
    end
    bus.iData_valid = 1'b0;
    #1;
    chk("fill0_sel",   32'(bus.oSelect), 32'h1);
    chk("fill0_busy",  32'(bus.oBusy), 32'h1);
    chk("fill0_rdreq", 32'(bus.oRdreq), 32'h0);
    tick();

    // Uninterrupted burst from bank 0.
    bus.iRd_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("b0_rdreq",  32'(bus.oRdreq), 32'h1);
      chk("b0_rdbank", 32'(bus.oRd_bank), 32'h0);
      chk("b0_rdval",  32'(bus.oRd_valid), 32'(i > 0));
      tick();
    end
    #1;
    chk("b0_end_rdreq", 32'(bus.oRdreq), 32'h0);
    chk("b0_end_rdval", 32'(bus.oRd_valid), 32'h1);
    chk("b0_end_busy",  32'(bus.oBusy), 32'h0);
    chk("b0_end_done",  32'(bus.oFrame_done), 32'h0);
    bus.iRd_enable = 1'b0;
    tick();

    // Fill bank 1, then a burst stalled for 2 cycles after the 3rd read.
    bus.iData_valid = 1'b1;
    for (int w = 0; w < 32; w++) begin
      #1;
      chk("fill1_wrreq", 32'(bus.oWrreq), 32'(1 << (w / 8)));
      tick();
    end
    bus.iData_valid = 1'b0;
    #1;
    chk("fill1_sel", 32'(bus.oSelect), 32'h0);
    tick();
    pat = 10'b11111_00_111;
    for (int i = 0; i < 10; i++) begin
      bus.iRd_enable = pat[i];
      #1;
      chk("stall_rdreq",  32'(bus.oRdreq), 32'(pat[i]));
      chk("stall_rdbank", 32'(bus.oRd_bank), 32'h1);
      tick();
    end
    bus.iRd_enable = 1'b0;
    #1;
    chk("stall_done",  32'(bus.oFrame_done), 32'h1);
    chk("stall_rdreq_end", 32'(bus.oRdreq), 32'h0);
    tick();
    #1;
    chk("stall_done_pulse", 32'(bus.oFrame_done), 32'h0);

    // Frame start clears; then both banks filled and 32 further words dropped.
    fs = 1'b1;
    tick();
    fs = 1'b0;
    #1;
    chk("fs1_busy", 32'(bus.oBusy), 32'h0);
    chk("fs1_sel",  32'(bus.oSelect), 32'h0);
    bus.iData_valid = 1'b1;
    for (int w = 0; w < 96; w++) begin
      #1;
      chk("ovf_wrreq", 32'(bus.oWrreq), (w < 64) ? 32'(1 << ((w % 32) / 8)) : 32'h0);
      if (w == 64) chk("ovf_before", 32'(bus.oOverflow), 32'h0);
      if (w == 65) chk("ovf_after",  32'(bus.oOverflow), 32'h1);
      tick();
    end
    bus.iData_valid = 1'b0;
    #1;
    chk("ovf_sel",  32'(bus.oSelect), 32'h1);
    chk("ovf_flag", 32'(bus.oOverflow), 32'h1);
    chk("ovf_busy", 32'(bus.oBusy), 32'h1);
`ifdef MFHWT_SCHED_STATS_EN
    chk("drop_cnt", 32'(bus.oDrop_cnt), 32'd32);
`endif

    // Two back-to-back bursts: bank 0 (held READ) then bank 1, ending the frame.
    bus.iRd_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("dbl_rdreq",  32'(bus.oRdreq), 32'h1);
      chk("dbl_rdbank", 32'(bus.oRd_bank), 32'(i / 8));
      chk("dbl_done",   32'(bus.oFrame_done), 32'h0);
      tick();
    end
    #1;
    chk("dbl_done_pulse", 32'(bus.oFrame_done), 32'h1);
    chk("dbl_rdreq_end",  32'(bus.oRdreq), 32'h0);
    tick();
    #1;
    chk("dbl_done_clear", 32'(bus.oFrame_done), 32'h0);
    chk("dbl_ovf_sticky", 32'(bus.oOverflow), 32'h1);
    chk("dbl_busy",       32'(bus.oBusy), 32'h0);
    bus.iRd_enable = 1'b0;

    // Frame start clears the sticky flag, then aborts a burst in progress.
    fs = 1'b1;
    tick();
    fs = 1'b0;
    #1;
    chk("fs2_ovf", 32'(bus.oOverflow), 32'h0);
`ifdef MFHWT_SCHED_STATS_EN
    chk("fs2_drop_cnt", 32'(bus.oDrop_cnt), 32'd0);
`endif
    bus.iData_valid = 1'b1;
    for (int w = 0; w < 32; w++) tick();
    bus.iData_valid = 1'b0;
    tick();
    bus.iRd_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("abort_rdreq", 32'(bus.oRdreq), 32'h1);
      tick();
    end
    fs = 1'b1;
    tick();
    fs = 1'b0;
    #1;
    chk("abort_rdreq_after", 32'(bus.oRdreq), 32'h0);
    chk("abort_rdval",       32'(bus.oRd_valid), 32'h0);
    chk("abort_busy",        32'(bus.oBusy), 32'h0);
    chk("abort_sel",         32'(bus.oSelect), 32'h0);
    tick();
    #1;
    chk("abort_rdreq_idle",  32'(bus.oRdreq), 32'h0);
    bus.iRd_enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
